// File: rtl/pwm_pkg.sv
// Shared constants, FSM state type and a range helper for the PWM duty-cycle controller.
package pwm_pkg;

  localparam int DUTY_W    = 4;
  localparam int PWM_STEPS = 10;

  typedef logic [DUTY_W-1:0] duty_t;

  localparam duty_t DUTY_MIN = 4'd1;
  localparam duty_t DUTY_MAX = 4'd9;
  localparam duty_t DUTY_RST = 4'd5;

  typedef enum logic [1:0] {
    MANUAL    = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } ctrl_state_e;

  // A duty value the 10-step PWM generator can render without 0 % or 100 % output.
  function automatic logic duty_in_range(input duty_t d);
    return (d >= DUTY_MIN) && (d <= DUTY_MAX) && (int'(d) < PWM_STEPS);
  endfunction

endpackage

// File: rtl/pwm_btn_debounce.sv
// One push-button path: 2-flop synchroniser, tick-sampled s1/s2 debounce pair and
// a one-cycle rising-edge press pulse.
module pwm_btn_debounce (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic btn_i,
  input  logic tick_i,
  output logic press_o
);

  logic sync1_q, sync2_q;
  logic s1_q, s2_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
    end else if (ena) begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      if (tick_i) begin
        s1_q <= sync2_q;
        s2_q <= s1_q;
      end
    end
  end

  // With tick tied high this reduces to a plain edge detect on the synchronised button.
  assign press_o = s1_q & ~s2_q & tick_i;

endmodule

// File: rtl/pwm_duty_ctrl.sv
// Duty-cycle controller: debounced buttons or triangle ramp stage duty_next, which is
// applied at PWM period boundaries. Define PWM_DEBOUNCE_EN to enable the tick-based debounce.
module pwm_duty_ctrl
  import pwm_pkg::*;
#(
  parameter int TICK_DIV  = 4,
  parameter int RAMP_HOLD = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              btn_inc,
  input  logic              btn_dec,
  input  logic              mode_ramp,
  input  logic              period_start,
  output logic [DUTY_W-1:0] duty_out,
  output logic              duty_upd,
  output logic              ramp_dir
);

  localparam int  HOLD_W    = (RAMP_HOLD > 1) ? $clog2(RAMP_HOLD) : 1;
  localparam bit  PARAMS_OK = (TICK_DIV >= 2) && (RAMP_HOLD >= 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RAMP_HOLD - 1);

  logic tick;
  logic press_inc, press_dec;

`ifdef PWM_DEBOUNCE_EN
  localparam int TICK_W = $clog2(TICK_DIV);

  logic [TICK_W-1:0] tick_cnt_q;
  logic              tick_last;

  assign tick_last = (tick_cnt_q == TICK_W'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
    end else if (ena) begin
      tick_cnt_q <= tick_last ? '0 : tick_cnt_q + TICK_W'(1);
    end
  end

  assign tick = tick_last;
`else
  assign tick = 1'b1;
`endif

  pwm_btn_debounce u_btn_inc (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .btn_i   (btn_inc),
    .tick_i  (tick),
    .press_o (press_inc)
  );

  pwm_btn_debounce u_btn_dec (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .btn_i   (btn_dec),
    .tick_i  (tick),
    .press_o (press_dec)
  );

  ctrl_state_e       state_q, state_d;
  duty_t             duty_next_q, duty_next_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  duty_t             duty_out_q;
  logic              duty_upd_q;
  logic              ramp_dir_q;
  logic              apply;

  // The applied value is the staged value from before this edge, so a coincident
  // press only lands at the following period.
  assign apply = period_start && (duty_next_q != duty_out_q);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    duty_next_d = duty_next_q;
    hold_d      = hold_q;
    unique case (state_q)
      MANUAL: begin
        if (mode_ramp) begin
          hold_d  = '0;
          state_d = (duty_next_q == DUTY_MAX) ? RAMP_DOWN : RAMP_UP;
        end else if (press_inc && !press_dec && (duty_next_q < DUTY_MAX)) begin
          duty_next_d = duty_next_q + duty_t'(1);
        end else if (press_dec && !press_inc && (duty_next_q > DUTY_MIN)) begin
          duty_next_d = duty_next_q - duty_t'(1);
        end
      end
      RAMP_UP, RAMP_DOWN: begin
        if (!mode_ramp) begin
          state_d = MANUAL;
        end else if (period_start) begin
          if (hold_q == HOLD_LAST) begin
            hold_d = '0;
            if (state_q == RAMP_UP) begin
              duty_next_d = duty_next_q + duty_t'(1);
              if (duty_next_d == DUTY_MAX) state_d = RAMP_DOWN;
            end else begin
              duty_next_d = duty_next_q - duty_t'(1);
              if (duty_next_d == DUTY_MIN) state_d = RAMP_UP;
            end
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
      end
      default: state_d = MANUAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= MANUAL;
      duty_next_q <= DUTY_RST;
      hold_q      <= '0;
      duty_out_q  <= DUTY_RST;
      duty_upd_q  <= 1'b0;
      ramp_dir_q  <= 1'b0;
    end else if (ena) begin
      state_q     <= state_d;
      duty_next_q <= duty_next_d;
      hold_q      <= hold_d;
      duty_upd_q  <= apply;
      ramp_dir_q  <= (state_d == RAMP_DOWN);
      if (apply) duty_out_q <= duty_next_q;
    end else begin
      duty_upd_q  <= 1'b0;
    end
  end

  assign duty_out = duty_out_q;
  assign duty_upd = duty_upd_q;
  assign ramp_dir = ramp_dir_q;

  a_params_ok : assert property (@(posedge clk) PARAMS_OK);
  a_duty_range : assert property (@(posedge clk) disable iff (!rst_n)
                                  duty_in_range(duty_out_q) && duty_in_range(duty_next_q));

endmodule
